// File: rtl/paddle_ctrl_pkg.sv
// Paddle stage types, play-field limits and the saturating move rule.
`include "config.v"

package paddle_ctrl_pkg;

  localparam int CENTRE_I = `V_DISP / 2 - `BODY_L / 2;
  localparam int Y_MIN_I  = `SLDE_W;
  localparam int Y_MAX_I  = `V_DISP - `SLDE_W - `BODY_L;

  localparam logic [9:0]  CENTRE = 10'(CENTRE_I);
  localparam logic [10:0] Y_MIN  = 11'(Y_MIN_I);
  localparam logic [10:0] Y_MAX  = 11'(Y_MAX_I);

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_RECENTRE = 2'd2
  } pad_state_e;

  typedef struct packed {
    pad_state_e st1;
    pad_state_e st0;
    logic       move_tick;
    logic [3:0] keys;       // {dn1, up1, dn0, up0}, debounced, 1 = pressed
  } pad_dbg_t;

  // Worked at 11 bits so that y - step near the top wall cannot wrap.
  function automatic logic [9:0] move_y(input logic [9:0]  y,
                                        input logic        up,
                                        input logic        dn,
                                        input logic [10:0] step);
    logic [10:0] y_w;
    logic [10:0] res;
    y_w = {1'b0, y};
    res = y_w;
    if (up && !dn) begin
      res = (y_w >= Y_MIN + step) ? (y_w - step) : Y_MIN;
    end else if (dn && !up) begin
      res = ((y_w + step) > Y_MAX) ? Y_MAX : (y_w + step);
    end
    return res[9:0];
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Control inputs and paddle positions between the game top, the paddle stage
// and the ball stage.
interface paddle_ctrl_if;
  import paddle_ctrl_pkg::*;

  // No valid/ready pairs: every field is a level sampled on vga_clk, except
  // guiwei which is a single-cycle pulse; padbody_y* are registered and hold
  // their value until the next move, recentre or reset.
  logic       start;
  logic       s;
  logic       guiwei;
  logic       key_up0;
  logic       key_dn0;
  logic       key_up1;
  logic       key_dn1;
  logic [9:0] padbody_y0;
  logic [9:0] padbody_y1;
  pad_dbg_t   dbg;

  modport master (
    output start, s, guiwei, key_up0, key_dn0, key_up1, key_dn1,
    input  padbody_y0, padbody_y1, dbg
  );

  modport slave (
    input  start, s, guiwei, key_up0, key_dn0, key_up1, key_dn1,
    output padbody_y0, padbody_y1, dbg
  );
endinterface

// File: rtl/config.v
// Shared display geometry for the pong datapath; every stage takes its screen
// constants from here so the ball and paddle stages always agree.
`ifndef PONG_CONFIG_V
`define PONG_CONFIG_V
`define V_DISP 480
`define SLDE_W 10
`define BODY_L 80
`endif

// File: rtl/paddle_ctrl_key_debounce.sv
// One push-button: 2-flop synchronizer then a level debouncer that only
// accepts a new level after DB_CYCLES unbroken cycles of it.
module key_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic vga_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic pressed
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_n;
  logic [CW-1:0] cnt;
  logic          level;

  assign level = ~sync_n[1];

  // Any cycle agreeing with the current output clears the run, so a bounce
  // restarts the whole window.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_n  <= 2'b11;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync_n <= {sync_n[0], key_n};
      if (level == pressed) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        pressed <= level;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Two-player paddle stage: debounced keys, a speed-selectable move tick and a
// per-paddle HOLD/PLAY/RECENTRE FSM producing registered top-edge positions.
module paddle_ctrl
  import paddle_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 250000,
  parameter int STEP      = 2,
  parameter int FAST_DIV  = 40000,
  parameter int SLOW_DIV  = 90000
) (
  input logic          vga_clk,
  input logic          sys_rst_n,
  paddle_ctrl_if.slave pif
);

  localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
  localparam int DW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam logic [10:0] STEP_W = 11'(STEP);

  logic [1:0]    up_k;
  logic [1:0]    dn_k;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_last;
  logic          move_tick;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_up0 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .key_n(pif.key_up0), .pressed(up_k[0]));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_dn0 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .key_n(pif.key_dn0), .pressed(dn_k[0]));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_up1 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .key_n(pif.key_up1), .pressed(up_k[1]));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_dn1 (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .key_n(pif.key_dn1), .pressed(dn_k[1]));

  // >= rather than == so a switch to the shorter period cannot strand the
  // counter above its new terminal value.
  assign div_last  = pif.s ? DW'(FAST_DIV - 1) : DW'(SLOW_DIV - 1);
  assign move_tick = (div_cnt >= div_last);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
    end else if (move_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_pad
    pad_state_e st;
    logic [9:0] y_q;

    // start low wins over everything; a goal beats a coincident move tick.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        st  <= ST_HOLD;
        y_q <= CENTRE;
      end else if (!pif.start) begin
        st  <= ST_HOLD;
        y_q <= CENTRE;
      end else begin
        case (st)
          ST_HOLD: begin
            st  <= ST_PLAY;
            y_q <= CENTRE;
          end
          ST_PLAY: begin
            if (pif.guiwei) begin
              st  <= ST_RECENTRE;
              y_q <= CENTRE;
            end else if (move_tick) begin
              y_q <= move_y(y_q, up_k[i], dn_k[i], STEP_W);
            end
          end
          ST_RECENTRE: begin
            st  <= ST_PLAY;
            y_q <= CENTRE;
          end
          default: begin
            st  <= ST_HOLD;
            y_q <= CENTRE;
          end
        endcase
      end
    end
  end

  assign pif.padbody_y0 = g_pad[0].y_q;
  assign pif.padbody_y1 = g_pad[1].y_q;

  assign pif.dbg = '{st1:       g_pad[1].st,
                     st0:       g_pad[0].st,
                     move_tick: move_tick,
                     keys:      {dn_k[1], up_k[1], dn_k[0], up_k[0]}};

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 250000, is the number of consecutive stable vga_clk cycles required to accept a key level change (10 ms at 25 MHz).
REQ-002 Parameter STEP, default 2, is the paddle displacement in pixels per move tick.
REQ-003 Parameter FAST_DIV, default 40000, is the move-tick period in vga_clk cycles when s=1.
REQ-004 Parameter SLOW_DIV, default 90000, is the move-tick period in vga_clk cycles when s=0.
REQ-005 vga_clk  input  1  the only clock; all state changes on its rising edge.
REQ-006 sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  game-run enable; 0 holds both paddles at centre.
REQ-008 s  input  1  speed select; 1 = fast (FAST_DIV), 0 = slow (SLOW_DIV).
REQ-009 guiwei  input  1  one-cycle goal pulse from the ball stage; requests recentre of both paddles.
REQ-010 key_up0, key_dn0  input  1 each  left paddle keys, active-low, asynchronous to vga_clk.
REQ-011 key_up1, key_dn1  input  1 each  right paddle keys, active-low, asynchronous to vga_clk.
REQ-012 padbody_y0  output  10  left paddle top-edge Y, registered; consumed by the ball stage.
REQ-013 padbody_y1  output  10  right paddle top-edge Y, registered; consumed by the ball stage.

Function
REQ-014 Each key SHALL pass a 2-flop synchronizer, then a debouncer whose output changes only after the synchronized level differs from the current output for DB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-015 Debounced key outputs SHALL be active-high "pressed"; their reset value SHALL be 0 (released).
REQ-016 A tick divider SHALL count 0..DIV-1 (DIV per s) and assert move_tick for one cycle at DIV-1; a change of s mid-count SHALL take effect without a stuck counter (count >= new DIV-1 wraps to 0 on the next cycle).
REQ-017 Constants: CENTRE = `V_DISP/2 - `body_l/2, Y_MIN = `SLDE_W, Y_MAX = `V_DISP - `SLDE_W - `body_l.
REQ-018 On move_tick with only up pressed, the paddle SHALL move to max(y-STEP, Y_MIN); this is computed at 11 bits, with no unsigned underflow.
REQ-019 On move_tick with only down pressed, the paddle SHALL move to min(y+STEP, Y_MAX).
REQ-020 Up and down pressed together, or neither pressed, SHALL leave the paddle unchanged.
REQ-021 The two paddles SHALL update independently on the same tick.
REQ-022 Each paddle SHALL use a 3-state FSM: HOLD (start=0, y forced to CENTRE), PLAY (moves per REQ-018..020), RECENTRE (y forced to CENTRE for exactly one cycle, then PLAY).
REQ-023 HOLD->PLAY when start=1; any state->HOLD when start=0; PLAY->RECENTRE on guiwei=1.
REQ-024 guiwei coinciding with move_tick SHALL take priority: the paddle goes to CENTRE and ignores the move.
REQ-025 start falling mid-tick SHALL force CENTRE on the next edge regardless of the tick.
REQ-026 Output latency: y SHALL update on the edge at which move_tick is high; keys reach move logic 2+DB_CYCLES cycles after a stable input.

Reset
REQ-027 While sys_rst_n=0, padbody_y0 and padbody_y1 SHALL be CENTRE, both FSMs HOLD, the divider 0, synchronizers and debouncers released.
REQ-028 Reset assertion mid-move SHALL take effect immediately (asynchronously); deassertion SHALL resume in HOLD.

Structure
REQ-029 Display constants (`V_DISP, `SLDE_W, `body_l) SHALL come only from the shared config.v include; no local redefinition.
REQ-030 One sub-module, key_debounce (synchronizer + debouncer, parameter DB_CYCLES), SHALL be instantiated four times.

Verification (bench config: V_DISP=480, SLDE_W=10, body_l=80, DB_CYCLES=8, SLOW_DIV=20, STEP=2 -> CENTRE=200, Y_MIN=10, Y_MAX=390)
REQ-031 Reset then start=1, no keys -> both outputs stay 200 for 10 ticks.
REQ-032 key_up0 held low -> padbody_y0 steps 200,198,... one step per 20 cycles and saturates at 10; padbody_y1 remains 200.
REQ-033 key_dn1 held low from y=389 (reach it via STEP=1 run or preload) -> 390 then holds at 390; both keys of one paddle pressed -> no change.
REQ-034 Key toggled with pulses shorter than 8 cycles -> no movement; a stable 8-cycle press -> movement begins at the next tick.
REQ-035 guiwei pulse on the same cycle as move_tick at y0=50 -> padbody_y0=200 next cycle, then normal movement resumes.
REQ-036 sys_rst_n pulled low asynchronously at y0=120 -> output 200 without waiting for a clock edge; start=0 -> both outputs 200 and keys ignored.
